// File: rtl/pixel_stream_pkg.sv
// Shared definitions for the pixel stream reader: FSM encoding and the
// default geometry constants (16-bit pixels, 4 pixels per vector,
// 784-pixel frames).
package pixel_stream_pkg;

    localparam int unsigned DEF_DATA_WIDTH  = 16;
    localparam int unsigned DEF_BEATS       = 4;
    localparam int unsigned DEF_FRAME_WORDS = 784;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/pixel_stream_reader.sv
// Pixel stream reader: pops BEATS words from an upstream synchronous FIFO,
// packs them (first word in the low lane) into one vector and presents it
// on a valid/ready port, flagging the last vector of each frame.
// Optional build macro PIXEL_READER_STALL_CNT_EN adds a saturating count of
// cycles spent waiting on an empty FIFO; without it stall_cycles is tied 0.
module pixel_stream_reader
    import pixel_stream_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int unsigned BEATS       = DEF_BEATS,
    parameter int unsigned FRAME_WORDS = DEF_FRAME_WORDS
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        enable,
    output logic                        fifo_rd_en,
    input  logic [DATA_WIDTH-1:0]       fifo_rd_data,
    input  logic                        fifo_rd_valid,
    input  logic                        fifo_empty,
    output logic [BEATS*DATA_WIDTH-1:0] out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        out_last,
    output logic [15:0]                 stall_cycles
);

    localparam int unsigned VECS = FRAME_WORDS / BEATS;
    localparam int unsigned CW   = $clog2(BEATS + 1);
    localparam int unsigned FW   = (VECS > 1) ? $clog2(VECS) : 1;

    localparam logic [CW-1:0] BEATS_C    = CW'(BEATS);
    localparam logic [CW-1:0] BEATS_M1_C = CW'(BEATS - 1);
    localparam logic [FW-1:0] LAST_VEC_C = FW'(VECS - 1);

    state_t                      r_state;
    state_t                      w_state_nxt;
    logic [CW-1:0]               r_issued;
    logic [CW-1:0]               r_captured;
    logic [FW-1:0]               r_frame_cnt;
    logic [BEATS*DATA_WIDTH-1:0] r_out_data;
    logic                        r_out_valid;
    logic                        w_rd_en;
    logic                        w_capture;
    logic                        w_last_beat;
    logic                        w_handshake;

    // Pops only while filling; the issued limit keeps the read side from
    // running ahead of the vector being assembled.
    assign w_rd_en     = (r_state == FILL) && enable && !fifo_empty && (r_issued < BEATS_C);
    // Stray read data outside FILL or beyond the lane count is dropped.
    assign w_capture   = fifo_rd_valid && (r_state == FILL) && (r_captured < BEATS_C);
    assign w_last_beat = w_capture && (r_captured == BEATS_M1_C);
    assign w_handshake = r_out_valid && out_ready;

    assign fifo_rd_en = w_rd_en;
    assign out_data   = r_out_data;
    assign out_valid  = r_out_valid;
    assign out_last   = r_out_valid && (r_frame_cnt == LAST_VEC_C);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: fill a vector, hold it until accepted, then refill or idle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (enable) w_state_nxt = FILL;
            FILL: if (w_last_beat) w_state_nxt = HOLD;
            HOLD: if (w_handshake) w_state_nxt = enable ? FILL : IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Datapath: pop/capture counters, lane packing, output valid and frame position.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_issued    <= '0;
            r_captured  <= '0;
            r_frame_cnt <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_rd_en) begin
                r_issued <= r_issued + 1'b1;
            end
            if (w_capture) begin
                r_captured <= r_captured + 1'b1;
            end
            for (int unsigned i = 0; i < BEATS; i++) begin
                if (w_capture && (r_captured == CW'(i))) begin
                    r_out_data[i*DATA_WIDTH +: DATA_WIDTH] <= fifo_rd_data;
                end
            end
            if (w_last_beat) begin
                r_out_valid <= 1'b1;
            end
            if (w_handshake) begin
                r_out_valid <= 1'b0;
                r_issued    <= '0;
                r_captured  <= '0;
                r_frame_cnt <= (r_frame_cnt == LAST_VEC_C) ? '0 : r_frame_cnt + 1'b1;
            end
        end
    end

`ifdef PIXEL_READER_STALL_CNT_EN
    logic [15:0] r_stall_cycles;

    // Saturating count of cycles where a pop was wanted but the FIFO was empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cycles <= '0;
        end else if ((r_state == FILL) && enable && fifo_empty && (r_issued < BEATS_C)
                     && (r_stall_cycles != 16'hFFFF)) begin
            r_stall_cycles <= r_stall_cycles + 16'd1;
        end
    end

    assign stall_cycles = r_stall_cycles;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_pixel_stream_reader.sv
// Self-checking bench for pixel_stream_reader. A behavioural synchronous
// FIFO (registered empty, read data one cycle after a pop) feeds the DUT;
// expected vectors are queued as words are pushed and compared on each
// output handshake.
module tb_pixel_stream_reader;

    localparam int unsigned DW    = 16;
    localparam int unsigned BEATS = 4;
    localparam int unsigned FWORD = 784;
    localparam int unsigned VECS  = FWORD / BEATS;
    localparam int unsigned DEPTH = 16;

    typedef struct {
        logic [63:0] data;
        logic        last;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic          out_ready = 1'b0;
    logic          fifo_rd_en;
    logic [DW-1:0] fifo_rd_data;
    logic          fifo_rd_valid;
    logic          fifo_empty;
    logic [63:0]   out_data;
    logic          out_valid;
    logic          out_last;
    logic [15:0]   stall_cycles;

    logic          push_en = 1'b0;
    logic [DW-1:0] push_data = '0;
    logic [DW-1:0] fq[$];

    exp_t          exp_q[$];
    exp_t          mon_e;
    logic [63:0]   pend = '0;
    int unsigned   pend_n = 0;
    int unsigned   vec_idx = 0;

    int unsigned   n_checks = 0;
    int unsigned   n_errors = 0;
    int unsigned   hs_cnt = 0;
    int unsigned   last_cnt = 0;
    int unsigned   viol = 0;
    int unsigned   exp_stall;

    always #5 clk = ~clk;

    pixel_stream_reader #(
        .DATA_WIDTH (DW),
        .BEATS      (BEATS),
        .FRAME_WORDS(FWORD)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_data (fifo_rd_data),
        .fifo_rd_valid(fifo_rd_valid),
        .fifo_empty   (fifo_empty),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_last     (out_last),
        .stall_cycles (stall_cycles)
    );

    // Upstream sync FIFO model, reset by the same rst_n.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fq.delete();
            fifo_empty    <= 1'b1;
            fifo_rd_valid <= 1'b0;
            fifo_rd_data  <= '0;
        end else begin
            fifo_rd_valid <= 1'b0;
            if (fifo_rd_en && fq.size() > 0) begin
                fifo_rd_data  <= fq.pop_front();
                fifo_rd_valid <= 1'b1;
            end
            if (push_en) fq.push_back(push_data);
            fifo_empty <= (fq.size() == 0);
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Output monitor: sampled just after the falling edge, once inputs have settled.
    always @(negedge clk) begin
        #1;
        if (rst_n) begin
            if (fifo_rd_en && fifo_empty) viol++;
            if (out_valid && out_ready) begin
                hs_cnt++;
                if (out_last) last_cnt++;
                if (exp_q.size() == 0) begin
                    check_eq("sb_unexpected_vec", 64'd1, 64'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check_eq("vec_data", out_data, mon_e.data);
                    check_eq("vec_last", {63'd0, out_last}, {63'd0, mon_e.last});
                end
            end
        end
    end

    // Called at a falling edge; the word enters the FIFO on the next rising edge.
    task automatic push_word(input logic [DW-1:0] d);
        int unsigned guard = 0;
        while (fq.size() >= DEPTH && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 2000) check_eq("push_timeout", 64'd1, 64'd0);
        push_en   = 1'b1;
        push_data = d;
        pend[pend_n*DW +: DW] = d;
        pend_n++;
        if (pend_n == BEATS) begin
            exp_q.push_back('{data: pend, last: ((vec_idx % VECS) == VECS - 1)});
            vec_idx++;
            pend_n = 0;
            pend   = '0;
        end
        @(negedge clk);
        push_en = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n   = 1'b0;
        push_en = 1'b0;
        exp_q.delete();
        pend    = '0;
        pend_n  = 0;
        vec_idx = 0;
        #1;
        check_eq("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check_eq("rst_out_data", out_data, 64'd0);
        check_eq("rst_out_last", {63'd0, out_last}, 64'd0);
        check_eq("rst_rd_en", {63'd0, fifo_rd_en}, 64'd0);
        check_eq("rst_stall", {48'd0, stall_cycles}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_drain(input int unsigned budget);
        int unsigned n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_eq("drain", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned n;
        int unsigned hs0;
        int unsigned l0;
        bit          rand_done;

`ifdef PIXEL_READER_STALL_CNT_EN
        exp_stall = 6;
`else
        exp_stall = 0;
`endif

        // Reset state
        do_reset();

        // Basic vector and latency from FILL entry
        enable    = 1'b0;
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) push_word(DW'(i));
        enable = 1'b1;
        @(posedge clk);
        n = 0;
        while (n < 50) begin
            @(posedge clk);
            n++;
            #1;
            if (out_valid) break;
        end
        check_eq("latency", 64'(n), 64'd5);
        check_eq("first_vec", out_data, 64'h0004_0003_0002_0001);
        @(posedge clk);
        #1;
        check_eq("valid_pulse", {63'd0, out_valid}, 64'd0);

        // Backpressure: vector held, no pops in HOLD, FIFO keeps 4 words
        @(negedge clk);
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) push_word(DW'(16'h0011 + i));
        repeat (10) @(negedge clk);
        check_eq("hold_valid", {63'd0, out_valid}, 64'd1);
        check_eq("hold_data", out_data, 64'h0014_0013_0012_0011);
        check_eq("hold_rd_en", {63'd0, fifo_rd_en}, 64'd0);
        check_eq("hold_fifo_level", 64'(fq.size()), 64'd4);
        check_eq("hold_last", {63'd0, out_last}, 64'd0);
        out_ready = 1'b1;
        wait_drain(200);

        // Empty FIFO mid-FILL: 6 stall cycles, lanes kept in order
        do_reset();
        enable    = 1'b0;
        out_ready = 1'b0;
        push_word(16'h0021);
        push_word(16'h0022);
        enable = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!fifo_empty && n < 20);
        repeat (5) @(negedge clk);
        push_word(16'h0023);
        push_word(16'h0024);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_eq("stall_vec", out_data, 64'h0024_0023_0022_0021);
        check_eq("stall_cycles", {48'd0, stall_cycles}, 64'(exp_stall));
        enable    = 1'b0;
        out_ready = 1'b1;
        wait_drain(100);

        // Full frame: 196 vectors, out_last only on the final one, then wrap
        do_reset();
        enable    = 1'b1;
        out_ready = 1'b1;
        hs0 = hs_cnt;
        l0  = last_cnt;
        for (int i = 0; i < int'(FWORD); i++) push_word(DW'(i) ^ 16'h5A00);
        wait_drain(5000);
        check_eq("frame_vectors", 64'(hs_cnt - hs0), 64'(VECS));
        check_eq("frame_lasts", 64'(last_cnt - l0), 64'd1);
        for (int i = 0; i < 4; i++) push_word(DW'(16'h00B0 + i));
        wait_drain(200);

        // Reset with a partially filled vector
        do_reset();
        enable    = 1'b1;
        out_ready = 1'b1;
        push_word(16'h00A1);
        push_word(16'h00A2);
        repeat (4) @(negedge clk);
        do_reset();
        for (int i = 0; i < 4; i++) push_word(DW'(16'h00C1 + i));
        wait_drain(200);

        // Random enable / out_ready over 1024 words
        hs0       = hs_cnt;
        rand_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 1024; i++) push_word(16'($urandom));
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(negedge clk);
                    enable    = ($urandom_range(0, 3) != 0);
                    out_ready = ($urandom_range(0, 1) != 0);
                end
            end
        join
        @(negedge clk);
        enable    = 1'b1;
        out_ready = 1'b1;
        wait_drain(8000);
        check_eq("random_vectors", 64'(hs_cnt - hs0), 64'd256);
        check_eq("rd_en_when_empty", 64'(viol), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
